// File: rtl/game_input_cond_pkg.sv
// Shared constants for the game front-end: button counts, channel
// indexing and the default debounce window.
package game_input_cond_pkg;

   localparam int NUM_PLAYERS      = 4;
   localparam int NUM_BTNS         = NUM_PLAYERS + 1;
   localparam int BTN_START        = NUM_BTNS - 1;
   localparam int CNT_W            = 32;
   localparam int DEBOUNCE_DEFAULT = 1000000;

endpackage : game_input_cond_pkg

// File: rtl/game_input_cond_btn_debounce.sv
// One push-button channel: 2-flop synchronizer, stability counter,
// debounced level and rising-edge detect of that level.
module btn_debounce
   import game_input_cond_pkg::*;
#(
   parameter int unsigned DebounceCycles = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DebounceCycles - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   // Bring the asynchronous button into the clock domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
      end
   end

   // Accept a new level only after it has been stable for the full window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync_p1 == level) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         level <= sync_p1;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Delayed copy of the level for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d <= 1'b0;
      end else begin
         level_d <= level;
      end
   end

   // High for the one cycle after the debounced level rises; the consumer
   // registers it, so its effect lands one edge after the level flips.
   assign rise = level & ~level_d;

endmodule : btn_debounce

// File: rtl/game_input_cond.sv
// Game input conditioning: debounces the start and per-player buttons,
// produces the new-game pulse and maintains the player-enable mask.
module game_input_cond
   import game_input_cond_pkg::*;
#(
   parameter int unsigned            DebounceCycles = DEBOUNCE_DEFAULT,
   parameter logic [NUM_PLAYERS-1:0] PlayersDefault = 4'b0011
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_btn_i,
   input  logic [NUM_PLAYERS-1:0] player_btn_i,
   input  logic                   line_active_i,
   output logic                   new_game_o,
   output logic [NUM_PLAYERS-1:0] player_en_o,
   output logic [NUM_BTNS-1:0]    btn_level_o
);

   logic [NUM_BTNS-1:0]    raw;
   logic [NUM_BTNS-1:0]    level;
   logic [NUM_BTNS-1:0]    rise;
   logic                   new_game;
   logic [NUM_PLAYERS-1:0] player_en;

   assign raw = {start_btn_i, player_btn_i};

   for (genvar k = 0; k < NUM_BTNS; k++) begin : g_ch
      btn_debounce #(
         .DebounceCycles(DebounceCycles)
      ) u_ch (
         .clk   (clk_i),
         .rst_n (rst_i),
         .raw   (raw[k]),
         .level (level[k]),
         .rise  (rise[k])
      );
   end

   // Registered start pulse; the running game does not suppress it
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         new_game <= 1'b0;
      end else begin
         new_game <= rise[BTN_START];
      end
   end

   // Toggle enables on player presses; presses during a running game are dropped
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         player_en <= PlayersDefault;
      end else if (!line_active_i) begin
         player_en <= player_en ^ rise[NUM_PLAYERS-1:0];
      end
   end

   assign new_game_o  = new_game;
   assign player_en_o = player_en;
   assign btn_level_o = level;

endmodule : game_input_cond

// File: tb/tb_game_input_cond.sv
// Scoreboard bench for game_input_cond with a 4-cycle debounce window.
// Stimulus pushes the expected output events (cycle stamp plus full output
// values); the monitor pops one whenever any output shows activity.
module tb_game_input_cond;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       start_btn_i = 1'b0;
   logic [3:0] player_btn_i = 4'b0000;
   logic       line_active_i = 1'b0;
   logic       new_game_o;
   logic [3:0] player_en_o;
   logic [4:0] btn_level_o;

   typedef struct {
      int         cyc;
      logic       ng;
      logic [3:0] pen;
      logic [4:0] lvl;
   } ev_t;

   ev_t        q[$];
   ev_t        e;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   logic [3:0] exp_pen = 4'b0011;
   logic [4:0] exp_lvl = 5'b00000;
   logic [3:0] prev_pen;
   logic [4:0] prev_lvl;
   bit         rst_seen = 1'b0;

   game_input_cond #(
      .DebounceCycles(4),
      .PlayersDefault(4'b0011)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_btn_i  (start_btn_i),
      .player_btn_i (player_btn_i),
      .line_active_i(line_active_i),
      .new_game_o   (new_game_o),
      .player_en_o  (player_en_o),
      .btn_level_o  (btn_level_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc++;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int c, input logic ng, input logic [3:0] pen, input logic [4:0] lvl);
      ev_t x;
      x.cyc = c;
      x.ng  = ng;
      x.pen = pen;
      x.lvl = lvl;
      q.push_back(x);
   endtask

   // Monitor: reset values while in reset, scoreboard pops on any activity
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (!rst_seen) begin
            check("reset_new_game", int'(new_game_o), 0);
            check("reset_player_en", int'(player_en_o), 4'b0011);
            check("reset_btn_level", int'(btn_level_o), 0);
            rst_seen = 1'b1;
         end
         prev_pen = 4'b0011;
         prev_lvl = 5'b00000;
      end else begin
         rst_seen = 1'b0;
         if (new_game_o || player_en_o != prev_pen || btn_level_o != prev_lvl) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event at cycle %0d: ng=%0b pen=%b lvl=%b, expected no activity",
                        cyc, new_game_o, player_en_o, btn_level_o);
            end else begin
               e = q.pop_front();
               check("event_cycle", cyc, e.cyc);
               check("new_game", int'(new_game_o), int'(e.ng));
               check("player_en", int'(player_en_o), int'(e.pen));
               check("btn_level", int'(btn_level_o), int'(e.lvl));
            end
         end
         prev_pen = player_en_o;
         prev_lvl = btn_level_o;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Press buttons right after an edge n for 'hold' cycles. pen_after is the
   // hand-computed enable mask after the press. With a window of 4 the level
   // rises after edge n+6, the pulse/toggle lands after n+7, and the level
   // falls after n+hold+6. Shorter presses produce nothing.
   task automatic press(input logic st, input logic [3:0] pl, input int hold,
                        input logic [3:0] pen_after);
      int         n;
      logic [4:0] m;
      m = {st, pl};
      @(posedge clk_i);
      #1;
      n = cyc;
      start_btn_i  = st;
      player_btn_i = pl;
      if (hold >= 4) begin
         exp_lvl = exp_lvl | m;
         push(n + 6, 1'b0, exp_pen, exp_lvl);
         if (st || pen_after != exp_pen) begin
            exp_pen = pen_after;
            push(n + 7, st, exp_pen, exp_lvl);
         end
         exp_lvl = exp_lvl & ~m;
         push(n + hold + 6, 1'b0, exp_pen, exp_lvl);
      end
      idle(hold);
      start_btn_i  = 1'b0;
      player_btn_i = 4'b0000;
      idle(20);
   endtask

   initial begin
      idle(3);
      rst_i = 1'b1;
      // All buttons low after reset: 20 quiet cycles
      idle(20);

      // Clean start press
      press(1'b1, 4'b0000, 10, 4'b0011);
      // Glitch shorter than the window
      press(1'b1, 4'b0000, 3, 4'b0011);
      // Two simultaneous player presses, then the same again to undo
      press(1'b0, 4'b0101, 10, 4'b0110);
      press(1'b0, 4'b0101, 10, 4'b0011);

      // Reset two cycles into a start press, button held through release
      begin
         int r;
         @(posedge clk_i);
         #1;
         start_btn_i = 1'b1;
         idle(2);
         rst_i = 1'b0;
         exp_pen = 4'b0011;
         exp_lvl = 5'b00000;
         idle(3);
         rst_i = 1'b1;
         r = cyc;
         push(r + 6, 1'b0, 4'b0011, 5'b10000);
         push(r + 7, 1'b1, 4'b0011, 5'b10000);
         push(r + 16, 1'b0, 4'b0011, 5'b00000);
         idle(10);
         start_btn_i = 1'b0;
         idle(20);
      end

      // Player 3 pressed during a running game is dropped, later press lands
      line_active_i = 1'b1;
      press(1'b0, 4'b1000, 10, 4'b0011);
      line_active_i = 1'b0;
      idle(5);
      press(1'b0, 4'b1000, 10, 4'b1011);

      // Start still fires during a running game; player press does not toggle
      line_active_i = 1'b1;
      press(1'b1, 4'b0010, 10, 4'b1011);
      line_active_i = 1'b0;

      // Press exactly as long as the window is accepted
      press(1'b0, 4'b0001, 4, 4'b1010);

      idle(20);
      check("scoreboard_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_game_input_cond

// File: doc/game_input_cond.md
GAME_INPUT_COND -- requirements
Module: game_input_cond

Interface
REQ-001 Parameter DebounceCycles, default 1000000, means the number of consecutive stable clock cycles required to accept a level change (10 ms at 100 MHz); legal values are 2 or more.
REQ-002 Parameter PlayersDefault, default 4'b0011, means the value of player_en_o after reset.
REQ-003 clk_i  input  1  system clock; the only clock.
REQ-004 rst_i  input  1  reset; asynchronous, active-low.
REQ-005 start_btn_i  input  1  raw start push-button; asynchronous; active-high.
REQ-006 player_btn_i  input  4  raw per-player enable push-buttons; asynchronous; active-high; bit k is player k.
REQ-007 line_active_i  input  1  game-running flag from the start stage; high means drawing is in progress.
REQ-008 new_game_o  output  1  single-cycle start pulse; feeds new_game_i of the start stage.
REQ-009 player_en_o  output  4  registered player-enable mask; feeds player_en of the start stage.
REQ-010 btn_level_o  output  5  debounced levels for status LEDs: {start, player[3:0]}.

Function
REQ-011 Each of the 5 raw inputs SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Each channel SHALL hold a debounced level and a 32-bit counter.
- Synced value equals the level: the counter clears to 0.
- Synced value differs and counter < DebounceCycles-1: the counter increments.
- Synced value differs and counter == DebounceCycles-1: the level takes the synced value and the counter clears.
REQ-013 A pulse shorter than DebounceCycles cycles after synchronization SHALL produce no level change and no output activity.
REQ-014 For each channel, a rising edge of the debounced level SHALL produce a registered one-cycle pulse. The pulse is high in the cycle after the level flips. Falling edges produce nothing.
REQ-015 Latency from the first clock edge that samples a new input value to the output pulse SHALL be DebounceCycles+3 clock edges.
REQ-016 new_game_o SHALL equal the start-channel pulse. It is never high for two consecutive cycles, and line_active_i does not gate it.
REQ-017 A player-channel k pulse SHALL toggle player_en_o[k] on the same edge that the pulse is registered, only when line_active_i==0. When line_active_i==1 the pulse is discarded, not queued.
REQ-018 Simultaneous pulses on several channels SHALL each take effect in the same cycle, independently of each other.
REQ-019 btn_level_o SHALL be the debounced levels, driven directly from registers.
REQ-020 A button held indefinitely SHALL yield exactly one pulse, with no auto-repeat.

Reset
REQ-021 While rst_i==0, the following SHALL be forced asynchronously:
- synchronizer flops, debounced levels, counters and pulse registers to 0;
- new_game_o=0, btn_level_o=0;
- player_en_o=PlayersDefault.
REQ-022 A button held through reset release SHALL be treated as a new press: it debounces and pulses once.
REQ-023 Reset asserted mid-count SHALL discard the partial count; no pulse is emitted for that press.

Structure
REQ-024 Constants NUM_PLAYERS=4, NUM_BTNS=5 and the default debounce count SHALL live in the shared game package used by the start stage.
REQ-025 One sub-module, btn_debounce, SHALL implement a single channel (synchronizer, counter, level, rising-edge pulse). It is instantiated NUM_BTNS times, parameterized by DebounceCycles.

Verification (bench uses DebounceCycles=4, PlayersDefault=4'b0011)
REQ-026 Reset release with all buttons low:
- new_game_o=0, player_en_o=4'b0011, btn_level_o=0 for 20 cycles.
REQ-027 start_btn_i high for 10 cycles from edge N:
- new_game_o high for exactly one cycle, after edge N+7;
- btn_level_o[4] high from after edge N+6.
REQ-028 start_btn_i glitches high for 3 cycles, then low:
- new_game_o stays 0;
- btn_level_o stays 0.
REQ-029 player_btn_i=4'b0101 held 10 cycles with line_active_i=0:
- player_en_o goes 4'b0011 -> 4'b0110 in one cycle;
- a second identical press returns it to 4'b0011.
REQ-030 player_btn_i[3] pressed while line_active_i=1, then line_active_i drops:
- player_en_o unchanged throughout;
- a new press after the drop sets bit 3.
REQ-031 rst_i asserted 2 cycles into a start press, released with the button still held:
- no pulse during reset;
- exactly one new_game_o pulse 7 edges after release.
